// File: rtl/mem_stage_dm.sv
// MEM-stage data memory for the 5-stage MIPS pipeline: little-endian word/half/byte
// stores, sign/zero-extending combinational loads, alignment flag and a one-cycle store trace.
module mem_stage_dm #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  input  logic [2:0]  load_op,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_SW = 2'b01;
  localparam logic [1:0] ST_SH = 2'b10;
  localparam logic [1:0] ST_SB = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           cur_word;
  logic [31:0]           merged_d;
  logic                  st_misalign;
  logic                  ld_misalign;
  logic                  store_commit;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;

  logic        trace_valid_q;
  logic [31:0] trace_pc_q;
  logic [31:0] trace_addr_q;
  logic [31:0] trace_data_q;

  // Upper address bits are dropped on purpose: accesses wrap modulo the depth.
  assign word_idx = addr[DEPTH_LOG2+1:2];
  assign cur_word = mem_q[word_idx];

  always_comb begin
    st_misalign = 1'b0;
    case (store_op)
      ST_SW:   st_misalign = (addr[1:0] != 2'b00);
      ST_SH:   st_misalign = addr[0];
      default: st_misalign = 1'b0;
    endcase
  end

  always_comb begin
    ld_misalign = 1'b0;
    case (load_op)
      LD_LW:         ld_misalign = (addr[1:0] != 2'b00);
      LD_LH, LD_LHU: ld_misalign = addr[0];
      default:       ld_misalign = 1'b0;
    endcase
  end

  assign align_err    = en & (st_misalign | ld_misalign);
  assign store_commit = en & (store_op != 2'b00) & ~align_err;

  always_comb begin
    merged_d = cur_word;
    case (store_op)
      ST_SW: merged_d = wdata;
      ST_SH: begin
        if (addr[1]) merged_d[31:16] = wdata[15:0];
        else         merged_d[15:0]  = wdata[15:0];
      end
      ST_SB: begin
        case (addr[1:0])
          2'd0:    merged_d[7:0]   = wdata[7:0];
          2'd1:    merged_d[15:8]  = wdata[7:0];
          2'd2:    merged_d[23:16] = wdata[7:0];
          default: merged_d[31:24] = wdata[7:0];
        endcase
      end
      default: merged_d = cur_word;
    endcase
  end

  assign half_sel = addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    case (addr[1:0])
      2'd0:    byte_sel = cur_word[7:0];
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
  end

  // Loads read the array as it stands; a same-cycle store becomes visible after the edge.
  always_comb begin
    rdata = 32'h0;
    if (!ld_misalign) begin
      case (load_op)
        LD_LW:   rdata = cur_word;
        LD_LH:   rdata = {{16{half_sel[15]}}, half_sel};
        LD_LHU:  rdata = {16'h0, half_sel};
        LD_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
        LD_LBU:  rdata = {24'h0, byte_sel};
        default: rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (store_commit) begin
      mem_q[word_idx] <= merged_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'h0;
      trace_addr_q  <= 32'h0;
      trace_data_q  <= 32'h0;
    end else begin
      trace_valid_q <= store_commit;
      if (store_commit) begin
        trace_pc_q   <= pc;
        trace_addr_q <= {addr[31:2], 2'b00};
        trace_data_q <= merged_d;
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- Data memory of the MEM stage in the 5-stage MIPS pipeline.
- Executes word, halfword and byte stores, and loads with sign or zero extension.
- Read result feeds the MEM/WB pipeline register as M_DM_OUT, combinationally, in the same cycle.
- Also produces an alignment-error flag and a registered one-cycle write-trace record for the testbench logger.

Parameters:
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (default 4096 words = 16 KiB).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- en  input  1  MEM-stage instruction valid; when 0, no store and no trace.
- pc  input  32  PC of the MEM-stage instruction, used for the trace.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (forwarded rt).
- store_op  input  2  00 none, 01 sw, 10 sh, 11 sb.
- load_op  input  3  000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 treated as none.
- rdata  output  32  extended load result, combinational.
- align_err  output  1  combinational; misaligned access.
- trace_valid  output  1  registered; a store committed on the previous edge.
- trace_pc  output  32  registered PC of that store.
- trace_addr  output  32  registered word-aligned address ({addr[31:2],2'b00}).
- trace_data  output  32  registered full merged word now in memory.

Behaviour:
- Storage: mem[0 .. 2^DEPTH_LOG2-1], 32-bit words.
  - Word index = addr[DEPTH_LOG2+1:2].
  - Upper address bits are ignored, so accesses wrap modulo depth.
- Reset (synchronous, clk edge with reset=1):
  - All memory words cleared to 0.
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0.
  - Any store presented in that cycle is discarded.
  - Reset in the middle of a store sequence leaves memory all-zero, with no partial writes.
- align_err:
  - Set for sw/lw when addr[1:0]!=0.
  - Set for sh/lh/lhu when addr[0]=1.
  - Byte ops are never misaligned.
  - Gated by en; 0 when no op is selected.
- Store (posedge, en=1, reset=0, align_err=0):
  - sw: word := wdata.
  - sh: halfword at addr[1] (0 = bits 15:0, 1 = bits 31:16) := wdata[15:0]; other half unchanged.
  - sb: byte at addr[1:0] (0 = bits 7:0 … 3 = bits 31:24) := wdata[7:0]; other bytes unchanged.
  - Little-endian byte lanes throughout.
- Misaligned store: memory unchanged, no trace.
- Trace register, updated every non-reset edge:
  - trace_valid <= store committed this edge.
  - When valid, trace_pc/addr/data load the store's pc, aligned address and merged word.
  - Otherwise trace_pc/addr/data hold their previous values.
- Load, combinational from the current array contents:
  - lw: word.
  - lh/lhu: selected half, sign- or zero-extended.
  - lb/lbu: selected byte, sign- or zero-extended.
  - none or misaligned: rdata=0.
- Read during write to the same word: rdata shows the old contents until the clock edge, and the new contents after it. No internal bypass; forwarding is the hazard unit's job.
- store_op and load_op both non-zero: illegal from decode. The store is still performed and rdata is still computed from the old contents; no assertion is required.
- en=0: store suppressed, align_err=0, rdata still computed from load_op.

Test Plan:
- Reset with memory pre-dirtied; apply sw addr=0x10 wdata=0xDEADBEEF pc=0x3000 -> next cycle trace_valid=1, trace_pc=0x3000, trace_addr=0x10, trace_data=0xDEADBEEF; lw 0x10 -> rdata=0xDEADBEEF; after reset, lw 0x10 -> 0.
- Word 0x20 = 0x11223344; sb addr=0x22 wdata=0xAA -> word 0x11AA3344; sh addr=0x20 wdata=0xBEEF -> word 0x11AABEEF, trace_data matches each time.
- Word 0x40 = 0x80FF7F01 -> lb 0x40 = 0x00000001, lb 0x42 = 0xFFFFFFFF, lbu 0x42 = 0x000000FF, lh 0x42 = 0xFFFF80FF, lhu 0x42 = 0x000080FF, lh 0x40 = 0x00007F01.
- sw addr=0x41 -> align_err=1, memory unchanged, trace_valid=0 next cycle; lh 0x43 -> align_err=1, rdata=0; lb 0x43 -> align_err=0.
- Wrap: DEPTH_LOG2=12; sw addr=0x4004 wdata=0x5 -> lw 0x4 returns 0x5; trace_addr=0x4004.
- en=0 with sw -> no write, trace_valid=0; same-cycle lw of the address being stored returns the old value, and the new value the cycle after.
